l1_bus_master: RTL
==================

# l1_bus_master

Per-L1 requester-side bus interface for the shared snooping MESI bus. Accepts one miss/upgrade/writeback request at a time from its L1 controller, raises `BusReq` toward the round-robin bus arbiter, and waits for `BusGrant`. It then issues the bus command, waits for the memory/snoop acknowledgement, returns the result to the L1, and releases the bus so the arbiter can rotate ownership. One instance sits beside each of the four L1 caches.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width per transaction
- `TIMEOUT`, 255, max `WAIT` cycles before abort (only with `BUS_TIMEOUT_EN`)

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `req_valid`  in  1  L1 request valid
- `req_ready`  out  1  high only in `IDLE`
- `req_cmd`  in  2  00 BusRd, 01 BusRdX, 10 BusUpgr, 11 Flush
- `req_addr`  in  ADDR_W  request address
- `req_wdata`  in  DATA_W  writeback data (Flush only)
- `resp_valid`  out  1  one-cycle completion pulse
- `resp_data`  out  DATA_W  read data (BusRd/BusRdX)
- `resp_shared`  out  1  another cache holds the line (BusRd → S, else E)
- `resp_err`  out  1  qualifies `resp_valid`: transaction aborted
- `BusReq`  out  1  request to arbiter
- `BusGrant`  in  1  this master's grant bit from arbiter
- `BusBusy`  out  1  drive-enable for the shared busy line (resolved wired-OR at top)
- `bus_cmd_valid`  out  1  one-cycle command strobe
- `bus_cmd`  out  2  latched command
- `bus_addr`  out  ADDR_W  latched address
- `bus_wdata`  out  DATA_W  latched write data
- `bus_ack`  in  1  transaction complete
- `bus_rdata`  in  DATA_W  data returned with ack
- `bus_shared`  in  1  snoop shared signal, valid with ack

## Operation
- FSM states: `IDLE`, `REQ`, `CMD`, `WAIT`, `RELEASE`. Outputs decode from registered state; `resp_*` are registered.
- `IDLE`: `req_ready`=1. When `req_valid`, latch cmd/addr/wdata → `REQ`.
- `REQ`: `BusReq`=1. When `BusGrant`=1 → `CMD`.
- `CMD`: `BusReq`=1, `BusBusy`=1, `bus_cmd_valid`=1 for exactly one cycle → `WAIT`.
- `WAIT`: `BusReq`=1, `BusBusy`=1. On `bus_ack`, capture `bus_rdata` and `bus_shared` into `resp_data`/`resp_shared` → `RELEASE`. `bus_ack` is ignored in every other state.
- Grant loss: `BusGrant`=0 while in `CMD`/`WAIT` without ack → `resp_err`=1 → `RELEASE`.
- `RELEASE`: `BusReq`=0, `BusBusy`=0. `resp_valid`=1 in the first cycle only. Remain until `BusGrant`=0, then → `IDLE`. This prevents re-request while the arbiter still shows the stale grant.
- `bus_cmd`/`bus_addr`/`bus_wdata` hold latched values from `IDLE` exit until the next accept.
- BusUpgr and Flush: `resp_data` is don't-care and `resp_shared` is 0.
- Reset values: state `IDLE`. `BusReq`, `BusBusy`, `bus_cmd_valid`, `resp_valid`, `resp_err`, and `resp_shared` are 0. `resp_data`, `bus_cmd`, `bus_addr`, and `bus_wdata` are 0. `req_ready`=1 from the first cycle after reset.
- Reset mid-transaction: abandon immediately, with no `resp_valid`. `BusReq` is 0 in the cycle after reset is sampled.

## Timing
- Accept at cycle 0 (`req_valid`&`req_ready`).
- Cycle 1: `BusReq`=1.
- Arbiter grant is registered. With the bus free, grant is seen at cycle 2, `bus_cmd_valid` at cycle 3, and `WAIT` from cycle 4.
- Ack at cycle k → `resp_valid` at k+1. Arbiter drops grant at k+2 → `IDLE` at k+3, accepting a new request at k+3 at the earliest.
- Minimum turnaround, accept to `resp_valid`, with ack in the first `WAIT` cycle: 5 cycles.
- `BusReq` stays high continuously from `REQ` through `WAIT`. This holds the arbiter lock.
- Timeout counter: 8+ bits (≥ clog2(TIMEOUT+1)). Clears on `WAIT` entry and increments each `WAIT` cycle without ack. At count == `TIMEOUT` → `resp_err`=1 → `RELEASE`. An ack arriving in the same cycle as timeout wins: normal completion.

## Configuration
- `BUS_TIMEOUT_EN` defined: watchdog counter present; a stalled `WAIT` aborts after `TIMEOUT` cycles with `resp_err`.
- Not defined: no counter logic; `WAIT` persists until `bus_ack` or grant loss.

## Test plan
- BusRd, free bus, ack in first `WAIT` cycle with rdata=0xDEADBEEF and shared=1 → `resp_valid` at cycle 5, `resp_data`=0xDEADBEEF, `resp_shared`=1, `resp_err`=0; `BusReq` high cycles 1–4.
- Flush with addr=0x1000 and wdata=0xA5A5A5A5, grant delayed 6 cycles → `bus_cmd_valid` single pulse with `bus_cmd`=11 and matching addr/data; `BusReq` never drops before ack.
- Back-to-back requests with `req_valid` held high → second accept only after `BusGrant` observed 0 in `RELEASE`; no `BusReq` high while stale grant=1.
- Grant deasserted in `WAIT` before ack → `resp_valid`=1 with `resp_err`=1 next cycle; `BusReq`=0.
- `BUS_TIMEOUT_EN` with `TIMEOUT`=10, no ack → `resp_err` pulse after 10 `WAIT` cycles. Repeat with ack on cycle 10 → normal response, `resp_err`=0.
- Reset asserted in `WAIT` → next cycle `BusReq`=0, `BusBusy`=0, `req_ready`=1, no `resp_valid`.

Source files
------------

// File: rtl/l1_bus_master_if.sv
`default_nettype none
// ============================================================================
// Module   : l1_bus_master_if
// Purpose  : L1-side request/response and arbitrated-bus signals of one master.
// Revision : 1.0
// ============================================================================
interface l1_bus_master_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic [1:0]        req_cmd;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              resp_valid;
   logic [DATA_W-1:0] resp_data;
   logic              resp_shared;
   logic              resp_err;
   logic              BusReq;
   logic              BusGrant;
   logic              BusBusy;
   logic              bus_cmd_valid;
   logic [1:0]        bus_cmd;
   logic [ADDR_W-1:0] bus_addr;
   logic [DATA_W-1:0] bus_wdata;
   logic              bus_ack;
   logic [DATA_W-1:0] bus_rdata;
   logic              bus_shared;

   modport master (
      input  req_valid, req_cmd, req_addr, req_wdata,
      input  BusGrant, bus_ack, bus_rdata, bus_shared,
      output req_ready, resp_valid, resp_data, resp_shared, resp_err,
      output BusReq, BusBusy, bus_cmd_valid, bus_cmd, bus_addr, bus_wdata
   );

   modport slave (
      output req_valid, req_cmd, req_addr, req_wdata,
      output BusGrant, bus_ack, bus_rdata, bus_shared,
      input  req_ready, resp_valid, resp_data, resp_shared, resp_err,
      input  BusReq, BusBusy, bus_cmd_valid, bus_cmd, bus_addr, bus_wdata
   );
endinterface
`default_nettype wire

// File: rtl/l1_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : l1_bus_master
// Purpose  : Per-L1 requester for the shared snooping bus; optional WAIT
//            watchdog enabled by defining BUS_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module l1_bus_master #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input wire              clk,
   input wire              reset,
   l1_bus_master_if.master bus
);
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      REQ     = 3'd1,
      CMD     = 3'd2,
      WAIT    = 3'd3,
      RELEASE = 3'd4
   } state_t;

   state_t state;
   state_t next_state;
   logic   accept;
   logic   complete;
   logic   abort;
   logic   timed_out;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state        = state;
      accept            = 1'b0;
      complete          = 1'b0;
      abort             = 1'b0;
      bus.req_ready     = 1'b0;
      bus.BusReq        = 1'b0;
      bus.BusBusy       = 1'b0;
      bus.bus_cmd_valid = 1'b0;
      unique case (state)
         IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid) begin
               accept     = 1'b1;
               next_state = REQ;
            end
         end
         REQ: begin
            bus.BusReq = 1'b1;
            if (bus.BusGrant) next_state = CMD;
         end
         CMD: begin
            bus.BusReq        = 1'b1;
            bus.BusBusy       = 1'b1;
            bus.bus_cmd_valid = 1'b1;
            if (!bus.BusGrant) begin
               abort      = 1'b1;
               next_state = RELEASE;
            end else begin
               next_state = WAIT;
            end
         end
         WAIT: begin
            bus.BusReq  = 1'b1;
            bus.BusBusy = 1'b1;
            // An ack beats both grant loss and the watchdog in the same cycle.
            if (bus.bus_ack) begin
               complete   = 1'b1;
               next_state = RELEASE;
            end else if (!bus.BusGrant || timed_out) begin
               abort      = 1'b1;
               next_state = RELEASE;
            end
         end
         RELEASE: begin
            // Hold off until the arbiter's registered grant has cleared.
            if (!bus.BusGrant) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bus.resp_valid  <= 1'b0;
         bus.resp_err    <= 1'b0;
         bus.resp_shared <= 1'b0;
         bus.resp_data   <= '0;
         bus.bus_cmd     <= 2'b00;
         bus.bus_addr    <= '0;
         bus.bus_wdata   <= '0;
      end else begin
         bus.resp_valid <= complete | abort;
         bus.resp_err   <= abort;
         if (accept) begin
            bus.bus_cmd   <= bus.req_cmd;
            bus.bus_addr  <= bus.req_addr;
            bus.bus_wdata <= bus.req_wdata;
         end
         if (complete) begin
            bus.resp_data   <= bus.bus_rdata;
            // Only BusRd/BusRdX (cmd[1]==0) report sharing.
            bus.resp_shared <= bus.bus_shared & ~bus.bus_cmd[1];
         end else if (abort) begin
            bus.resp_shared <= 1'b0;
         end
      end
   end

`ifdef BUS_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

   logic [CNT_W-1:0] wait_cnt;

   always_ff @(posedge clk) begin
      if (reset || state != WAIT) wait_cnt <= '0;
      else if (!bus.bus_ack)      wait_cnt <= wait_cnt + CNT_W'(1);
   end

   // The TIMEOUT-th consecutive ack-less WAIT cycle aborts.
   assign timed_out = (wait_cnt == CNT_W'(TIMEOUT - 1));
`else
   assign timed_out = 1'b0;
`endif

endmodule
`default_nettype wire
